// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO.
// One shift-add or restoring-divide step per cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OpMthi = 3'b100;
  localparam logic [2:0] OpMtlo = 3'b101;
  localparam logic [CNT_W-1:0] LastCnt =
    CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    Idle,
    Run,
    Fin
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             isDiv;
  logic             negQ;
  logic             negR;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lsr;
  logic [WIDTH-1:0] opd;

  logic             iterOp;
  logic             isSigned;
  logic             aNeg;
  logic             bNeg;
  logic             bZero;
  logic             accept;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;

  assign iterOp   = ~op[2];
  assign isSigned = ~op[0];
  assign aNeg     = iterOp & isSigned & a_i[WIDTH-1];
  assign bNeg     = iterOp & isSigned & b_i[WIDTH-1];
  assign aMag     = aNeg ? -a_i : a_i;
  assign bMag     = bNeg ? -b_i : b_i;
  assign bZero    = (b_i == '0);
  assign accept   = start & ~cancel & (state != Run);

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divSh;
  logic [WIDTH-1:0] divDiff;
  logic             divGe;
  logic [WIDTH-1:0] accN;
  logic [WIDTH-1:0] lsrN;

  // acc:lsr is product high:low, or remainder:dividend/quotient
  always_comb begin
    mulSum  = {1'b0, acc}
            + (lsr[0] ? {1'b0, opd} : '0);
    divSh   = {acc, lsr[WIDTH-1]};
    divDiff = divSh[WIDTH-1:0] - opd;
    divGe   = divSh >= {1'b0, opd};
    if (isDiv) begin
      accN = divGe ? divDiff : divSh[WIDTH-1:0];
      lsrN = {lsr[WIDTH-2:0], divGe};
    end else begin
      accN = mulSum[WIDTH:1];
      lsrN = {mulSum[0], lsr[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  assign prodMag = {accN, lsrN};
  assign prod    = negQ ? -prodMag : prodMag;
  assign quo     = negQ ? -lsrN : lsrN;
  assign rem     = negR ? -accN : accN;
  assign resHi   = isDiv ? rem : prod[2*WIDTH-1:WIDTH];
  assign resLo   = isDiv ? quo : prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= Idle;
      cnt   <= '0;
      isDiv <= 1'b0;
      negQ  <= 1'b0;
      negR  <= 1'b0;
      acc   <= '0;
      lsr   <= '0;
      opd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        Run: begin
          if (cancel) begin
            state <= Idle;
            busy  <= 1'b0;
          end else begin
            acc <= accN;
            lsr <= lsrN;
            cnt <= cnt + 1'b1;
            if (cnt == LastCnt) begin
              hi_o  <= resHi;
              lo_o  <= resLo;
              state <= Fin;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= Idle;
          if (accept) begin
            unique case (1'b1)
              iterOp: begin
                isDiv <= op[1];
                // x/0 yields all-ones quotient regardless of sign
                negQ  <= (aNeg ^ bNeg)
                       & ~(op[1] & bZero);
                negR  <= aNeg;
                acc   <= '0;
                lsr   <= aMag;
                opd   <= bMag;
                cnt   <= '0;
                state <= Run;
                busy  <= 1'b1;
              end
              op == OpMthi: hi_o <= a_i;
              op == OpMtlo: lo_o <= a_i;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized bench for mdu_iter (WIDTH 32 and 8)
// against an arithmetic reference model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op(op), .a_i(a), .b_i(b),
    .cancel(cancel), .busy(busy32),
    .done(done32), .hi_o(hi32), .lo_o(lo32)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start),
    .op(op), .a_i(a[7:0]), .b_i(b[7:0]),
    .cancel(cancel), .busy(busy8),
    .done(done8), .hi_o(hi8), .lo_o(lo8)
  );

  always #5 clk = ~clk;

  // Reference arithmetic on w-bit operands.
  function automatic void refOp(
    input int w, input logic [2:0] o,
    input logic [31:0] x, input logic [31:0] y,
    output logic [31:0] hi, output logic [31:0] lo);
    longint mask, ua, ub, sa, sb, q, r;
    longint unsigned pu;
    mask = (longint'(1) << w) - 1;
    ua = longint'(x) & mask;
    ub = longint'(y) & mask;
    sa = (ua >= (longint'(1) << (w - 1)))
       ? ua - (longint'(1) << w) : ua;
    sb = (ub >= (longint'(1) << (w - 1)))
       ? ub - (longint'(1) << w) : ub;
    hi = 32'd0;
    lo = 32'd0;
    case (o)
      3'd0: begin
        q  = sa * sb;
        hi = 32'((q >>> w) & mask);
        lo = 32'(q & mask);
      end
      3'd1: begin
        pu = longint'(unsigned'(ua))
           * longint'(unsigned'(ub));
        pu = longint'(unsigned'(ua)) * longint'(unsigned'(ub));
        hi = 32'((pu >> w) & longint'(unsigned'(mask)));
        lo = 32'(pu & longint'(unsigned'(mask)));
      end
      3'd2: begin
        if (ub == 0) begin
          hi = 32'(ua);
          lo = 32'(mask);
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          hi = 32'(r & mask);
          lo = 32'(q & mask);
        end
      end
      3'd3: begin
        if (ub == 0) begin
          hi = 32'(ua);
          lo = 32'(mask);
        end else begin
          hi = 32'((ua % ub) & mask);
          lo = 32'((ua / ub) & mask);
        end
      end
      default: ;
    endcase
  endfunction

  // Model state per instance: 0 = WIDTH 32, 1 = WIDTH 8
  logic [31:0] mHi[2], mLo[2], pHi[2], pLo[2];
  bit          mBusy[2], mDone[2];
  int          left[2];

  function automatic int wOf(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] mskOf(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mHi[k] = 0; mLo[k] = 0; pHi[k] = 0; pLo[k] = 0;
        mBusy[k] = 0; mDone[k] = 0; left[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mDone[k] = 0;
        if (mBusy[k]) begin
          if (cancel) begin
            mBusy[k] = 0;
          end else begin
            left[k] = left[k] - 1;
            if (left[k] == 0) begin
              mBusy[k] = 0;
              mHi[k] = pHi[k];
              mLo[k] = pLo[k];
              mDone[k] = 1;
            end
          end
        end else if (start && !cancel) begin
          case (op)
            3'd4: mHi[k] = a & mskOf(k);
            3'd5: mLo[k] = a & mskOf(k);
            3'd0, 3'd1, 3'd2, 3'd3: begin
              refOp(wOf(k), op, a, b, pHi[k], pLo[k]);
              mBusy[k] = 1;
              left[k] = wOf(k);
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic cmp(input string name,
                     input logic [65:0] got,
                     input logic [65:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp("cyc32", {busy32, done32, hi32, lo32},
          {mBusy[0], mDone[0], mHi[0], mLo[0]});
      cmp("cyc8",
          {busy8, done8, 24'd0, hi8, 24'd0, lo8},
          {mBusy[1], mDone[1], mHi[1], mLo[1]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    cyc();
    start = 1'b0;
  endtask

  task automatic runOp(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       output int n);
    issue(o, x, y);
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      cyc();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'hFFFF_FF80;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] h, l;
    int n;
    bit sawDone;

    refOp(32, 3'd0, 32'hFFFF_FFFD, 32'd5, h, l);
    cmp("ref_mult", {2'b0, h, l},
        {2'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    refOp(8, 3'd2, 32'h9C, 32'h07, h, l);
    cmp("ref_div8", {2'b0, h, l},
        {2'b0, 32'h0000_00FE, 32'h0000_00F2});
    refOp(32, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
    cmp("ref_minneg1", {2'b0, h, l},
        {2'b0, 32'h0, 32'h8000_0000});

    #1 rst = 1'b0;
    armed = 1'b1;
    repeat (2) cyc();
    cmp("reset", {busy32, done32, hi32, lo32}, 66'd0);
    rst = 1'b1;
    cyc();

    runOp(3'd0, 32'hFFFF_FFFD, 32'd5, n);
    cmp("mult_busy", 66'(n), 66'd32);
    cmp("mult_res", {busy32, done32, hi32, lo32},
        {2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFF1});

    runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    cmp("multu_res", {busy32, done32, hi32, lo32},
        {2'b01, 32'hFFFF_FFFE, 32'h0000_0001});
    runOp(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    cmp("div_b2b_busy", 66'(n), 66'd32);
    cmp("div_res", {busy32, done32, hi32, lo32},
        {2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFD});

    runOp(3'd3, 32'd7, 32'd0, n);
    cmp("divu_zero", {busy32, done32, hi32, lo32},
        {2'b01, 32'h0000_0007, 32'hFFFF_FFFF});
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    cmp("div_min", {busy32, done32, hi32, lo32},
        {2'b01, 32'h0, 32'h8000_0000});

    cyc();
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    cyc();
    cmp("mthi", {busy32, done32, hi32},
        {2'b00, 32'h1234_5678});
    op = 3'd5; a = 32'h9ABC_DEF0;
    cyc();
    start = 1'b0;
    cmp("mtlo", {busy32, done32, hi32, lo32},
        {2'b00, 32'h1234_5678, 32'h9ABC_DEF0});

    issue(3'd0, 32'd2, 32'd3);
    repeat (3) cyc();
    issue(3'd5, 32'h0000_DEAD, 32'd0);
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      cyc();
    end
    cmp("mtlo_busy", {busy32, done32, hi32, lo32},
        {2'b01, 32'h0, 32'h6});

    issue(3'd0, 32'd6, 32'd7);
    repeat (9) cyc();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    cmp("cancel", {busy32, done32, hi32, lo32},
        {2'b00, 32'h0, 32'h6});
    sawDone = 1'b0;
    repeat (40) begin
      cyc();
      if (done32) sawDone = 1'b1;
    end
    cmp("cancel_nodone", 66'(sawDone), 66'd0);

    issue(3'd3, 32'd100, 32'd3);
    repeat (5) cyc();
    #2 rst = 1'b0;
    #1;
    cmp("async_rst", {busy32, done32, hi32, lo32},
        66'd0);
    cyc();
    rst = 1'b1;
    cyc();

    issue(3'd2, 32'hFFFF_FF9C, 32'd7);
    n = 0;
    while (busy8 && n < 100) begin
      n++;
      cyc();
    end
    cmp("div8_busy", 66'(n), 66'd8);
    cmp("div8_res", {48'd0, busy8, done8, hi8, lo8},
        {48'd0, 2'b01, 8'hFE, 8'hF2});
    repeat (30) cyc();

    for (int i = 0; i < 15000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      cancel = ($urandom_range(0, 49) == 0);
      op     = 3'($urandom_range(0, 7));
      a      = pick();
      b      = pick();
      cyc();
    end
    start = 1'b0;
    cancel = 1'b0;
    repeat (40) cyc();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Replaces the current combinational HI/LO path in EXU plus the separate HI/LO register file.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and also services MTHI/MTLO.
- Raises busy so the pipeline/control can stall HI/LO consumers until the result lands.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  request; accepted only on a rising edge where busy=0 and cancel=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- a_i  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b_i  in  WIDTH  rt operand: multiplier or divisor.
- cancel  in  1  flush; aborts an in-flight operation.
- busy  out  1  high while an iterative operation is running.
- done  out  1  one-cycle pulse; HI/LO updated by an iterative op.
- hi_o  out  WIDTH  current HI register.
- lo_o  out  WIDTH  current LO register.

Behaviour:
- Reset (rst=0, any time, including mid-operation):
  - state=IDLE; hi_o=0, lo_o=0, busy=0, done=0; counter and datapath cleared.
  - The in-flight operation is lost.
- States:
  - IDLE: no operation in progress.
  - RUN: iterating.
  - FIN: one-cycle completion state in which done=1.
- IDLE, start=1, cancel=0:
  - op MTHI: hi_o<=a_i at this edge; state stays IDLE; no busy; no done.
  - op MTLO: lo_o<=a_i at this edge; state stays IDLE; no busy; no done.
  - op 110/111: ignored.
  - op MULT/MULTU/DIV/DIVU: latch operands and op.
    - Signed ops latch |a_i|, |b_i| and the result signs.
    - cnt<=0; state->RUN.
- RUN:
  - One iteration per cycle: shift-add multiply, or restoring divide with a WIDTH+1-bit partial remainder.
  - cnt increments each cycle.
  - On the edge where cnt reaches WIDTH-1, apply sign correction, write hi_o/lo_o, and go to FIN.
- FIN: done=1 for exactly this cycle; then IDLE. A start in FIN is accepted normally (back-to-back issue).
- busy timing:
  - busy=1 in RUN only, i.e. exactly WIDTH cycles following the accepting edge.
  - hi_o/lo_o show the new values in the same cycle done=1, which is WIDTH+1 edges after accept.
- Multiply result:
  - hi_o:lo_o = full 2*WIDTH-bit product.
  - Signed product is negated when the operand signs differ.
- Divide result:
  - lo_o = quotient, hi_o = remainder.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (b_i=0): still takes WIDTH cycles; lo_o = all ones, hi_o = a_i unchanged.
- Signed MIN / -1: lo_o = MIN, hi_o = 0. No trap; this falls out of the unsigned-magnitude datapath.
- start while busy=1: ignored, no queueing. The requester must hold or re-issue.
- cancel:
  - In RUN: state->IDLE at the next edge; hi_o/lo_o unchanged; busy drops; no done.
  - In IDLE: blocks start in the same cycle, including MTHI/MTLO.
  - In FIN: no effect; the result is already committed.
- hi_o/lo_o are registers and are never partially updated; intermediate state is internal only.

Test Plan:
- WIDTH=32, MULT a=FFFFFFFD (-3), b=00000005 -> busy high 32 cycles, done at edge 33; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then DIV a=FFFFFFF9 (-7), b=2 issued in the FIN cycle -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=7, b=0 -> lo=FFFFFFFF, hi=00000007. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- MTHI a=12345678, then MTLO a=9ABCDEF0 on consecutive cycles -> hi/lo update at each edge, busy never set, no done. A MULT started, then MTLO issued while busy -> MTLO ignored.
- MULT 6*7 with cancel at RUN cycle 10 -> busy drops next edge, hi/lo keep prior values, no done. rst=0 asserted mid-DIVU -> all outputs 0 immediately (asynchronous).
- WIDTH=8 build: DIV a=8'h9C (-100), b=8'h07 -> busy 8 cycles, lo=8'hF2 (-14), hi=8'hFE (-2).
